// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//
// Writer-side front end for the patch-embedding weight SRAM. A byte-packed
// stream of kernel weights arrives over a valid/ready interface. Each group of
// elements/beat_bytes beats is assembled into one full SRAM row. That row is
// then written through a single-cycle write port. One start command loads a
// contiguous range of rows beginning at start_row. The range wraps modulo
// kernels.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   start        one-cycle load command, sampled only while idle
//   start_row    first SRAM row to write
//   num_kernels  number of rows to load (0..kernels)
//   s_valid      stream beat valid
//   s_ready      block can accept a beat (registered, high only while filling)
//   s_data       beat payload; byte b is s_data[b*bit_width +: bit_width]
//   w_en         SRAM write enable, one cycle per kernel
//   w_row_addr   SRAM write row
//   data_in      assembled row presented to the SRAM
//   busy         high from start acceptance until the command completes
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module weight_loader #(
  parameter int bit_width  = 8,
  parameter int kernels    = 64,
  parameter int size       = 16,
  parameter int channels   = 3,
  parameter int elements   = size * size * channels,
  parameter int beat_bytes = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [$clog2(kernels)-1:0]          start_row,
  input  logic [$clog2(kernels):0]            num_kernels,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [beat_bytes*bit_width-1:0]     s_data,
  output logic                                w_en,
  output logic [$clog2(kernels)-1:0]          w_row_addr,
  output logic [elements*bit_width-1:0]       data_in,
  output logic                                busy,
  output logic                                done
);

  localparam int beats  = elements / beat_bytes;
  localparam int beat_w = beat_bytes * bit_width;
  localparam int row_w  = $clog2(kernels);
  localparam int cnt_w  = $clog2(beats);

  localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);
  localparam logic [row_w-1:0] last_row  = row_w'(kernels - 1);
  localparam logic [row_w:0]   one_left  = (row_w + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t                        state;
  logic [cnt_w-1:0]              beat_cnt;
  logic [row_w:0]                kernels_left;
  logic [row_w-1:0]              row;
  logic [elements*bit_width-1:0] buffer;
  logic [elements*bit_width-1:0] buffer_next;

  // Buffer with the current beat merged in. The final beat of a row is written
  // straight into data_in, so w_en can follow the last accepted beat by one cycle.
  // NOTE: every always_comb output gets a full default first; a path that skips
  // the assignment would otherwise infer a latch.
  always_comb begin
    buffer_next = buffer;
    buffer_next[int'(beat_cnt) * beat_w +: beat_w] = s_data;
  end

  // NOTE: state registers use non-blocking assignments only, so every branch
  // reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the assembly buffer is cleared on reset, unlike a true RAM. It is
      // a flop array, and data_in must read back as zero after reset.
      state        <= IDLE;
      s_ready      <= 1'b0;
      w_en         <= 1'b0;
      w_row_addr   <= '0;
      data_in      <= '0;
      buffer       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      beat_cnt     <= '0;
      kernels_left <= '0;
      row          <= '0;
    end else begin
      // Single-cycle pulses default low; only the state that raises them overrides.
      w_en <= 1'b0;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            row          <= start_row;
            kernels_left <= num_kernels;
            if (num_kernels != '0) begin
              state   <= FILL;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end else begin
              // Empty command: complete immediately without touching the SRAM.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        FILL: begin
          if (s_valid && s_ready) begin
            buffer <= buffer_next;
            if (beat_cnt == last_beat) begin
              beat_cnt   <= '0;
              state      <= WRITE;
              s_ready    <= 1'b0;
              w_en       <= 1'b1;
              w_row_addr <= row;
              data_in    <= buffer_next;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        WRITE: begin
          row          <= (row == last_row) ? '0 : row + 1'b1;
          kernels_left <= kernels_left - 1'b1;
          if (kernels_left == one_left) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//
// Self-checking bench for weight_loader. The reference model builds each
// kernel as a plain byte array and derives the expected (row, data) writes and
// the stream beats from it. Expected writes go into a scoreboard queue. A
// monitor pops that queue on every w_en and compares the write against it.
// -----------------------------------------------------------------------------
module tb_weight_loader;

  localparam int bit_width  = 8;
  localparam int kernels    = 64;
  localparam int size       = 16;
  localparam int channels   = 3;
  localparam int elements   = size * size * channels;
  localparam int beat_bytes = 8;
  localparam int beats      = elements / beat_bytes;
  localparam int row_w      = $clog2(kernels);
  localparam int data_w     = elements * bit_width;
  localparam int beat_w     = beat_bytes * bit_width;

  typedef logic [data_w-1:0] row_t;
  typedef struct {
    logic [row_w-1:0] row;
    row_t             data;
  } write_t;

  logic               clk;
  logic               reset;
  logic               start;
  logic [row_w-1:0]   start_row;
  logic [row_w:0]     num_kernels;
  logic               s_valid;
  logic               s_ready;
  logic [beat_w-1:0]  s_data;
  logic               w_en;
  logic [row_w-1:0]   w_row_addr;
  row_t               data_in;
  logic               busy;
  logic               done;

  weight_loader #(
    .bit_width (bit_width),
    .kernels   (kernels),
    .size      (size),
    .channels  (channels),
    .beat_bytes(beat_bytes)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_row  (start_row),
    .num_kernels(num_kernels),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .w_en       (w_en),
    .w_row_addr (w_row_addr),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare a whole row by its first differing byte, which keeps the report short.
  task automatic check_row(input string name, input row_t act, input row_t exp);
    int  idx;
    bit  found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < elements; i++) begin
      if (!found && act[i*bit_width +: bit_width] !== exp[i*bit_width +: bit_width]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    check($sformatf("%s byte %0d", name, idx),
          64'(act[idx*bit_width +: bit_width]), 64'(exp[idx*bit_width +: bit_width]));
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard and stream driver state
  // ---------------------------------------------------------------------------
  write_t            exp_q[$];
  logic [beat_w-1:0] beat_q[$];
  bit                gaps     = 1'b0;
  bit                hold_off = 1'b0;
  int                accepted = 0;
  int                last_present_cyc = 0;

  // Stream driver: offer the head beat, randomly withheld when gaps are on.
  // s_ready is registered, so the value seen here decides the next edge.
  always @(negedge clk) begin
    if (!hold_off && beat_q.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
      s_valid = 1'b1;
      s_data  = beat_q[0];
    end else begin
      s_valid = 1'b0;
      s_data  = {$urandom, $urandom};
    end
    if (s_valid && s_ready) begin
      void'(beat_q.pop_front());
      accepted++;
      last_present_cyc = cyc;
    end
  end

  // Monitor: every SRAM write must match the head of the scoreboard.
  int wen_cnt      = 0;
  int done_cnt     = 0;
  int wen_cyc      = 0;
  int prev_wen_cyc = 0;
  int done_cyc     = 0;

  always @(negedge clk) begin : monitor
    write_t e;
    if (w_en) begin
      wen_cnt++;
      prev_wen_cyc = wen_cyc;
      wen_cyc      = cyc;
      check("s_ready during write", 64'(s_ready), 64'(0));
      check("busy during write", 64'(busy), 64'(1));
      if (exp_q.size() == 0) begin
        check("unexpected w_en", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("w_row_addr", 64'(w_row_addr), 64'(e.row));
        check_row("data_in", data_in, e.data);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy at done", 64'(busy), 64'(0));
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: build kernel bytes, derive expected writes and beats.
  // mode 0: byte = element index mod 256; mode 1: byte = k+1; mode 2: random.
  // ---------------------------------------------------------------------------
  task automatic queue_load(input int srow, input int n, input int mode);
    row_t d;
    logic [bit_width-1:0] b;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < elements; i++) begin
        case (mode)
          0:       b = bit_width'(i % 256);
          1:       b = bit_width'(k + 1);
          default: b = bit_width'($urandom);
        endcase
        d[i*bit_width +: bit_width] = b;
      end
      exp_q.push_back('{row: row_w'((srow + k) % kernels), data: d});
      for (int j = 0; j < beats; j++) beat_q.push_back(d[j*beat_w +: beat_w]);
    end
  endtask

  task automatic issue_start(input int srow, input int n, output int start_c);
    @(negedge clk);
    start       = 1'b1;
    start_row   = row_w'(srow);
    num_kernels = (row_w + 1)'(n);
    start_c     = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input int srow, input int n, input int mode, input bit with_gaps);
    int w0, d0, start_c;
    gaps = with_gaps;
    queue_load(srow, n, mode);
    w0 = wen_cnt;
    d0 = done_cnt;
    issue_start(srow, n, start_c);
    for (int t = 0; t < n * 400 + 20 && done_cnt == d0; t++) @(negedge clk);
    check("done pulses", 64'(done_cnt - d0), 64'(1));
    check("w_en pulses", 64'(wen_cnt - w0), 64'(n));
    if (n == 0) begin
      check("empty cmd done latency", 64'(done_cyc - start_c), 64'(1));
    end else begin
      check("w_en after last beat", 64'(wen_cyc - last_present_cyc), 64'(1));
      check("done after last w_en", 64'(done_cyc - wen_cyc), 64'(1));
      if (n > 1 && !with_gaps)
        check("w_en spacing", 64'(wen_cyc - prev_wen_cyc), 64'(beats + 1));
    end
    check("scoreboard drained", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("busy after done", 64'(busy), 64'(0));
    check("done is one cycle", 64'(done), 64'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " s_ready"}, 64'(s_ready), 64'(0));
    check({tag, " w_en"}, 64'(w_en), 64'(0));
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " done"}, 64'(done), 64'(0));
    check({tag, " w_row_addr"}, 64'(w_row_addr), 64'(0));
    check({tag, " data_in nonzero"}, 64'(|data_in), 64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int a0, w0, d0, start_c;
    reset       = 1'b1;
    start       = 1'b0;
    start_row   = '0;
    num_kernels = '0;
    s_valid     = 1'b0;
    s_data      = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle s_ready", 64'(s_ready), 64'(0));

    // Single kernel, element-index pattern, back to back.
    load(5, 1, 0, 1'b0);

    // Wrap across the last row with constant-valued rows.
    load(62, 3, 1, 1'b0);

    // Random valid gaps with random data.
    load(int'($urandom_range(0, kernels - 1)), 3, 2, 1'b1);

    // A second start issued mid-load must be ignored.
    fork
      load(20, 2, 2, 1'b0);
      begin
        repeat (150) @(negedge clk);
        start       = 1'b1;
        start_row   = row_w'(10);
        num_kernels = (row_w + 1)'(1);
        @(negedge clk);
        start = 1'b0;
      end
    join

    // Reset after 50 beats of a kernel: no write, no done, reset values.
    gaps = 1'b0;
    queue_load(30, 2, 2);
    w0 = wen_cnt;
    d0 = done_cnt;
    a0 = accepted;
    issue_start(30, 2, start_c);
    for (int t = 0; t < 500 && accepted < a0 + 50; t++) @(posedge clk);
    check("beats before reset", 64'(accepted - a0), 64'(50));
    #1;
    reset    = 1'b1;
    hold_off = 1'b1;
    beat_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    check_reset_values("mid-load reset");
    @(negedge clk);
    reset    = 1'b0;
    hold_off = 1'b0;
    repeat (5) @(negedge clk);
    check("w_en after reset", 64'(wen_cnt - w0), 64'(0));
    check("done after reset", 64'(done_cnt - d0), 64'(0));

    // Fresh load after the aborted one must carry no stale bytes.
    load(7, 1, 2, 1'b1);

    // Empty command.
    load(int'($urandom_range(0, kernels - 1)), 0, 2, 1'b0);

    // Full range from a random start row: every row written once, wrapping.
    load(int'($urandom_range(1, kernels - 1)), kernels, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
